// File: rtl/wb_arbiter_pkg.sv
// Shared register-file widths and the write-back record used by the arbiter,
// the register heap and decode.
package wb_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'h0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] val;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// DEPTH-entry circular buffer for MDU results, exposing per-entry valid/addr
// so the arbiter can flag registers with an outstanding write.
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DATA_W = REG_DATA_W,
    parameter int DEPTH  = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic [ADDR_W-1:0]             push_addr,
    input  logic [DATA_W-1:0]             push_val,
    input  logic                          pop,
    output logic [ADDR_W-1:0]             head_addr,
    output logic [DATA_W-1:0]             head_val,
    output logic [CNT_W-1:0]              count,
    output logic [DEPTH-1:0]              entry_valid,
    output logic [DEPTH-1:0][ADDR_W-1:0]  entry_addr
);

    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [DATA_W-1:0] mem_val  [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1))
            return '0;
        return p + 1'b1;
    endfunction

    // NOTE: storage is not reset; validity comes only from rd_ptr and count,
    // so clearing the pointers is enough to discard every entry.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= push_addr;
            mem_val[wr_ptr]  <= push_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= next_ptr(wr_ptr);
            if (pop)
                rd_ptr <= next_ptr(rd_ptr);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head_addr = mem_addr[rd_ptr];
    assign head_val  = mem_val[rd_ptr];

    // An entry is live when its distance from the head is below count.
    always_comb begin
        int offset;
        offset      = 0;
        entry_valid = '0;
        entry_addr  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset = i - int'(rd_ptr);
            if (offset < 0)
                offset = offset + DEPTH;
            entry_valid[i] = (offset < int'(count));
            entry_addr[i]  = mem_addr[i];
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Merges the never-stalled pipeline write-back and queued MDU results onto the
// register heap's single write port, with pending flags for decode stalls.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pipe_we,
    input  logic [ADDR_W-1:0] pipe_addr,
    input  logic [DATA_W-1:0] pipe_val,
    input  logic              mdu_valid,
    output logic              mdu_ready,
    input  logic [ADDR_W-1:0] mdu_addr,
    input  logic [DATA_W-1:0] mdu_val,
    input  logic [ADDR_W-1:0] query_addr1,
    input  logic [ADDR_W-1:0] query_addr2,
    input  logic [ADDR_W-1:0] query_addr3,
    output logic              pending1,
    output logic              pending2,
    output logic              pending3,
    output logic              write_enable,
    output logic [ADDR_W-1:0] write_addr,
    output logic [DATA_W-1:0] write_val
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

    logic                         accept;
    logic                         push;
    logic                         pop;
    logic                         pipe_hit;
    logic [ADDR_W-1:0]            head_addr;
    logic [DATA_W-1:0]            head_val;
    logic [CNT_W-1:0]             count;
    logic [CNT_W-1:0]             count_next;
    logic [DEPTH-1:0]             entry_valid;
    logic [DEPTH-1:0][ADDR_W-1:0] entry_addr;

    // Writes to the zero register carry no state: they never enqueue or take the slot.
    assign accept     = mdu_valid && mdu_ready;
    assign push       = accept && (mdu_addr != ZERO_ADDR);
    assign pipe_hit   = pipe_we && (pipe_addr != ZERO_ADDR);
    assign pop        = !pipe_hit && (count != '0);
    assign count_next = count + CNT_W'(push) - CNT_W'(pop);

    wb_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (push),
        .push_addr   (mdu_addr),
        .push_val    (mdu_val),
        .pop         (pop),
        .head_addr   (head_addr),
        .head_val    (head_val),
        .count       (count),
        .entry_valid (entry_valid),
        .entry_addr  (entry_addr)
    );

    // mdu_ready is registered from the post-update count, so a push can never
    // land on a full FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdu_ready    <= 1'b0;
            write_enable <= 1'b0;
            write_addr   <= '0;
            write_val    <= '0;
        end else begin
            mdu_ready    <= (count_next < CNT_W'(DEPTH));
            write_enable <= pipe_hit || pop;
            if (pipe_hit) begin
                write_addr <= pipe_addr;
                write_val  <= pipe_val;
            end else if (pop) begin
                write_addr <= head_addr;
                write_val  <= head_val;
            end
        end
    end

    // The output register is deliberately excluded; the heap's bypass covers it.
    always_comb begin
        logic [2:0][ADDR_W-1:0] query;
        logic [2:0]             hit;
        query = {query_addr3, query_addr2, query_addr1};
        hit   = '0;
        for (int k = 0; k < 3; k++) begin
            if (query[k] != ZERO_ADDR) begin
                if (accept && (mdu_addr == query[k]))
                    hit[k] = 1'b1;
                for (int i = 0; i < DEPTH; i++) begin
                    if (entry_valid[i] && (entry_addr[i] == query[k]))
                        hit[k] = 1'b1;
                end
            end
        end
        pending1 = hit[0];
        pending2 = hit[1];
        pending3 = hit[2];
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic, all compared
// against a queue-based model of the write-back arbitration rules.
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pipe_we;
    logic [4:0]  pipe_addr;
    logic [31:0] pipe_val;
    logic        mdu_valid;
    logic        mdu_ready;
    logic [4:0]  mdu_addr;
    logic [31:0] mdu_val;
    logic [4:0]  query_addr1, query_addr2, query_addr3;
    logic        pending1, pending2, pending3;
    logic        write_enable;
    logic [4:0]  write_addr;
    logic [31:0] write_val;

    int checks = 0;
    int errors = 0;

    // Reference model state
    wb_entry_t   m_q[$];
    logic        m_ready;
    logic        m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_val;

    always #5 clk = ~clk;

    wb_arbiter #(.DATA_W(32), .ADDR_W(5), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pipe_we      (pipe_we),
        .pipe_addr    (pipe_addr),
        .pipe_val     (pipe_val),
        .mdu_valid    (mdu_valid),
        .mdu_ready    (mdu_ready),
        .mdu_addr     (mdu_addr),
        .mdu_val      (mdu_val),
        .query_addr1  (query_addr1),
        .query_addr2  (query_addr2),
        .query_addr3  (query_addr3),
        .pending1     (pending1),
        .pending2     (pending2),
        .pending3     (pending3),
        .write_enable (write_enable),
        .write_addr   (write_addr),
        .write_val    (write_val)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ready = 1'b0;
        m_we    = 1'b0;
        m_addr  = '0;
        m_val   = '0;
    endtask

    function automatic logic model_pending(input logic [4:0] a);
        if (a == 5'd0)
            return 1'b0;
        if (mdu_valid && m_ready && mdu_addr == a)
            return 1'b1;
        foreach (m_q[i])
            if (m_q[i].addr == a)
                return 1'b1;
        return 1'b0;
    endfunction

    // One clock edge of the arbitration rules, applied to the current inputs.
    task automatic model_edge();
        logic      acc;
        logic      phit;
        wb_entry_t e;
        acc  = mdu_valid && m_ready;
        phit = pipe_we && (pipe_addr != 5'd0);
        if (phit) begin
            m_we = 1'b1; m_addr = pipe_addr; m_val = pipe_val;
        end else if (m_q.size() > 0) begin
            e = m_q.pop_front();
            m_we = 1'b1; m_addr = e.addr; m_val = e.val;
        end else begin
            m_we = 1'b0;
        end
        if (acc && mdu_addr != 5'd0)
            m_q.push_back('{addr: mdu_addr, val: mdu_val});
        m_ready = (m_q.size() < DEPTH);
    endtask

    // Called at posedge+1 with inputs driven; checks pre-edge and post-edge outputs.
    task automatic cycle();
        #1;
        check("pending1", pending1, model_pending(query_addr1));
        check("pending2", pending2, model_pending(query_addr2));
        check("pending3", pending3, model_pending(query_addr3));
        check("mdu_ready", mdu_ready, m_ready);
        model_edge();
        @(posedge clk);
        #1;
        check("write_enable", write_enable, m_we);
        check("write_addr", write_addr, m_addr);
        check("write_val", write_val, m_val);
    endtask

    task automatic drive(input logic pwe, input logic [4:0] pa, input logic [31:0] pv,
                         input logic mv, input logic [4:0] ma, input logic [31:0] mval);
        pipe_we = pwe; pipe_addr = pa; pipe_val = pv;
        mdu_valid = mv; mdu_addr = ma; mdu_val = mval;
    endtask

    task automatic set_query(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3);
        query_addr1 = a1; query_addr2 = a2; query_addr3 = a3;
    endtask

    initial begin
        int k;
        logic acc;

        // Reset held with both sources requesting
        rst_n = 1'b0;
        drive(1'b1, 5'd4, 32'h1111_2222, 1'b1, 5'd6, 32'h3333_4444);
        set_query(5'd6, 5'd4, 5'd6);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_write_enable", write_enable, 1'b0);
        check("rst_mdu_ready", mdu_ready, 1'b0);
        check("rst_pending", {pending1, pending2, pending3}, 3'b000);
        check("rst_write_addr", write_addr, 5'd0);

        rst_n = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        cycle();
        check("ready_after_release", mdu_ready, 1'b1);

        // Pipeline only, then a dropped write to r0
        drive(1'b1, 5'd3, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0);
        cycle();
        check("pipe_addr3", {write_enable, write_addr, write_val}, {1'b1, 5'd3, 32'hDEAD_BEEF});
        drive(1'b1, 5'd0, 32'hCAFE_0000, 1'b0, 5'd0, 32'h0);
        cycle();
        check("pipe_addr0_dropped", write_enable, 1'b0);
        check("pipe_addr0_hold", write_addr, 5'd3);

        // MDU with idle pipeline
        set_query(5'd7, 5'd1, 5'd7);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h1234_5678);
        cycle();
        check("mdu_pending_queued", pending1, 1'b1);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        cycle();
        check("mdu_written", {write_enable, write_addr, write_val}, {1'b1, 5'd7, 32'h1234_5678});
        cycle();
        check("mdu_pending_cleared", pending1, 1'b0);

        // Contention: pipeline busy for 5 cycles while MDU pushes 8 then 9
        set_query(5'd8, 5'd9, 5'd2);
        k = 0;
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, 5'(16 + c), 32'hA000_0000 + c, k < 2, 5'(8 + k), 32'h8000_0000 + k);
            acc = mdu_valid && m_ready;
            cycle();
            if (acc) k++;
        end
        check("contention_ready_low", mdu_ready, 1'b0);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        cycle();
        check("contention_first", write_addr, 5'd8);
        cycle();
        check("contention_second", write_addr, 5'd9);
        cycle();
        check("contention_ready_back", mdu_ready, 1'b1);

        // Push and pop in the same cycle at count=1
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 32'h0000_00AA);
        cycle();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd11, 32'h0000_00BB);
        cycle();
        check("pushpop_head", write_addr, 5'd10);
        check("pushpop_ready", mdu_ready, 1'b1);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        cycle();
        check("pushpop_order", {write_enable, write_addr, write_val}, {1'b1, 5'd11, 32'h0000_00BB});

        // Async reset with two entries queued behind a busy pipeline
        for (int c = 0; c < 2; c++) begin
            drive(1'b1, 5'd20, 32'h5555_0000 + c, 1'b1, 5'(12 + c), 32'h7777_0000 + c);
            cycle();
        end
        check("queued_two", m_q.size(), 2);
        rst_n = 1'b0;
        #1;
        check("async_reset_we", write_enable, 1'b0);
        model_reset();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cycle();
            check("no_stale_write", write_enable, 1'b0);
        end

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom);
            set_query(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Write-back arbiter directly upstream of the register heap's single write port.
- Merges two write sources into one registered write per cycle:
  - the in-order pipeline write-back, which is never stalled;
  - results from the multi-cycle mul/div unit (MDU), which use a valid/ready handshake.
- MDU results wait in a small FIFO until the pipeline leaves a write slot free.
- Exposes per-address pending flags so decode can stall on registers whose MDU result has not yet been written.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register address width
- DEPTH, 2, MDU result FIFO entries; legal range 1..4

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- pipe_we  in  1  pipeline write-back request this cycle
- pipe_addr  in  ADDR_W  pipeline destination register
- pipe_val  in  DATA_W  pipeline write data
- mdu_valid  in  1  MDU result available
- mdu_ready  out  1  arbiter can accept an MDU result
- mdu_addr  in  ADDR_W  MDU destination register
- mdu_val  in  DATA_W  MDU result data
- query_addr1  in  ADDR_W  decode rs address
- query_addr2  in  ADDR_W  decode rt address
- query_addr3  in  ADDR_W  decode destination address
- pending1  out  1  query_addr1 has an outstanding MDU write
- pending2  out  1  query_addr2 has an outstanding MDU write
- pending3  out  1  query_addr3 has an outstanding MDU write
- write_enable  out  1  to register heap write_enable
- write_addr  out  ADDR_W  to register heap write_addr
- write_val  out  DATA_W  to register heap write_val

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - write_enable=0, write_addr=0, write_val=0.
  - FIFO empty (rd_ptr=wr_ptr=count=0).
  - mdu_ready=0 while rst_n is low.
  - pending1..3=0.
- mdu_ready: registered. Equals (count < DEPTH) from the cycle after reset deassertion.
- Accept: an MDU transfer occurs on a rising edge with mdu_valid && mdu_ready.
  - mdu_addr==0: the result is accepted and discarded (not enqueued).
  - Otherwise: push {addr,val} at wr_ptr; wr_ptr increments modulo DEPTH.
- Each cycle, the output register loads in priority order:
  1. pipe_we && pipe_addr!=0 -> {1, pipe_addr, pipe_val}.
  2. Else FIFO non-empty -> pop head: {1, head.addr, head.val}; rd_ptr increments modulo DEPTH.
  3. Else -> write_enable=0; write_addr and write_val hold their previous values.
- Pipeline writes to address 0 are dropped and do not consume the slot.
- Latency: pipeline write appears at the outputs exactly 1 cycle after its request.
- MDU minimum latency: 2 cycles (accept edge -> FIFO -> output edge) when the pipeline is idle.
- Ordering: MDU results leave in acceptance order. The arbiter never reorders against the pipeline; decode prevents WAW/RAW hazards via pending3 and pending1/2.
- Push and pop in the same cycle: count unchanged. Pushing while full is impossible because ready is registered from count.
- count update rule: count_next = count + push - pop. mdu_ready_next = (count_next < DEPTH).
- pending_k (combinational) is 1 when query_addr_k != 0 and equals either:
  - the addr of any valid FIFO entry, or
  - mdu_addr of a transfer being accepted this cycle.
- The output register is not included in pending; the register heap's write bypass covers that cycle.
- Starvation: a continuously busy pipeline may starve the FIFO indefinitely. Decode stalls on pending, which eventually frees write slots. No timeout.
- Reset mid-operation: the FIFO contents and any in-flight output write are discarded immediately. The MDU must treat an unaccepted result as lost.

Decomposition:
- Shared package holds:
  - REG_ADDR_W=5, REG_DATA_W=32, REG_ZERO=5'h0 (shared with the register heap and decode).
  - The wb_entry record {addr, val}.
- One sub-module is natural: wb_fifo, a parameterised DEPTH-entry circular buffer.
  - Exposes push, pop, head, count and per-entry valid/addr vectors for the pending compare.
  - The arbiter instantiates it and adds priority selection, the output register and the query comparators.

Test Plan:
- Reset: hold rst_n=0 with pipe_we=1, mdu_valid=1 -> write_enable=0, mdu_ready=0, pending=0. Release rst_n -> mdu_ready=1 on the next edge.
- Pipeline only: pipe_we=1, addr=3, val=0xDEADBEEF at cycle N -> cycle N+1 shows write_enable=1, write_addr=3, write_val=0xDEADBEEF. Then addr=0 -> write_enable=0.
- MDU with idle pipeline: mdu addr=7, val=0x12345678 accepted at N -> pending for addr 7 is 1 at N and N+1; write appears at N+1; pending clears at N+2.
- Contention: pipeline writes every cycle for 5 cycles while MDU pushes addr 8 then 9 (DEPTH=2):
  - mdu_ready drops to 0 after the 2nd accept.
  - After the pipeline stops, addr 8 and addr 9 are written on consecutive cycles.
  - mdu_ready returns to 1.
- Simultaneous push and pop at count=1 -> count stays 1, mdu_ready stays 1, FIFO order preserved (FIFO head is written, then the new entry).
- Async reset asserted with 2 entries queued -> write_enable falls immediately. After release, no stale write of either entry appears.
